// File: rtl/vlc_switch_conditioner_if.sv
// -----------------------------------------------------------------------------
// vlc_switch_conditioner_if
// Connects the driver switches and the clean lamp commands of the tail-light
// sequencer's front end.
//   sw_left / sw_right / sw_emerg : raw asynchronous switch levels
//   turn_left / turn_right        : clean turn commands
//   emergency                     : clean hazard command
//   conflict                      : left and right both held, no hazard
//   cmd_change                    : one-cycle pulse on any command change
// Modports: master = switch/lamp side (drives switches),
//           slave  = conditioner (drives commands).
// -----------------------------------------------------------------------------
interface vlc_switch_conditioner_if;
  logic sw_left;
  logic sw_right;
  logic sw_emerg;
  logic turn_left;
  logic turn_right;
  logic emergency;
  logic conflict;
  logic cmd_change;

  modport master (
    output sw_left, sw_right, sw_emerg,
    input  turn_left, turn_right, emergency, conflict, cmd_change
  );

  modport slave (
    input  sw_left, sw_right, sw_emerg,
    output turn_left, turn_right, emergency, conflict, cmd_change
  );
endinterface

// File: rtl/vlc_switch_conditioner.sv
// -----------------------------------------------------------------------------
// vlc_switch_conditioner
// Synchronizes and debounces the left/right/hazard switches, arbitrates
// conflicting requests and registers clean lamp commands.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (released synchronously upstream)
//   bus   : vlc_switch_conditioner_if.slave (switch inputs, command outputs)
// Parameters:
//   SAMPLE_DIV : clock cycles between debounce strobes (>= 2)
//   DEB_COUNT  : consecutive disagreeing strobes to accept a level (1..15)
// Optional feature macro: VLC_HAZARD_TOGGLE_EN
//   defined   : sw_emerg is a momentary button; each debounced press toggles
//               a hazard latch.
//   undefined : hazard follows the debounced sw_emerg level.
// Channel index: 0 = left, 1 = right, 2 = hazard.
// -----------------------------------------------------------------------------
module vlc_switch_conditioner #(
  parameter int SAMPLE_DIV = 4,
  parameter int DEB_COUNT  = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  vlc_switch_conditioner_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [3:0]  DEB_LAST = 4'(DEB_COUNT);

  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [15:0]     r_div;
  logic            w_strobe;
  logic [2:0]      r_stable;
  logic [2:0]      w_stable_nxt;
  logic [2:0][3:0] r_cnt;
  logic [2:0][3:0] w_cnt_nxt;
  logic            w_h;
  logic            w_emerg_nxt;
  logic            w_left_nxt;
  logic            w_right_nxt;
  logic            w_conflict_nxt;
  logic            w_change_nxt;
  logic            r_turn_left;
  logic            r_turn_right;
  logic            r_emergency;
  logic            r_conflict;
  logic            r_cmd_change;

  assign w_raw = {bus.sw_emerg, bus.sw_right, bus.sw_left};

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample divider; the strobe marks its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 16'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= 16'd0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  assign w_strobe = (r_div == DIV_LAST);

  // Debounce next state: count disagreeing strobes, flip stable on the Nth.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    for (int ch = 0; ch < 3; ch++) begin
      if (w_strobe) begin
        if (r_sync2[ch] != r_stable[ch]) begin
          if ((r_cnt[ch] + 4'd1) == DEB_LAST) begin
            w_stable_nxt[ch] = ~r_stable[ch];
            w_cnt_nxt[ch]    = 4'd0;
          end else begin
            w_cnt_nxt[ch]    = r_cnt[ch] + 4'd1;
          end
        end else begin
          w_cnt_nxt[ch] = 4'd0;
        end
      end else begin
        w_cnt_nxt[ch] = r_cnt[ch];
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 3'b000;
      r_cnt    <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

`ifdef VLC_HAZARD_TOGGLE_EN
  logic r_haz_latch;

  // Hazard latch flips on the cycle the debounced button goes high, so it
  // lines up with the stable bits of the other channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_haz_latch <= 1'b0;
    end else if (w_stable_nxt[2] && !r_stable[2]) begin
      r_haz_latch <= ~r_haz_latch;
    end else begin
      r_haz_latch <= r_haz_latch;
    end
  end

  assign w_h = r_haz_latch;
`else
  assign w_h = r_stable[2];
`endif

  // Arbitration: hazard wins, then left+right conflict, then plain turns.
  always_comb begin
    w_emerg_nxt    = 1'b0;
    w_left_nxt     = 1'b0;
    w_right_nxt    = 1'b0;
    w_conflict_nxt = 1'b0;
    if (w_h) begin
      w_emerg_nxt = 1'b1;
    end else if (r_stable[0] && r_stable[1]) begin
      w_conflict_nxt = 1'b1;
    end else begin
      w_left_nxt  = r_stable[0];
      w_right_nxt = r_stable[1];
    end
    // conflict is deliberately excluded from the change detector
    w_change_nxt = ({w_emerg_nxt, w_left_nxt, w_right_nxt} !=
                    {r_emergency, r_turn_left, r_turn_right});
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_turn_left  <= 1'b0;
      r_turn_right <= 1'b0;
      r_emergency  <= 1'b0;
      r_conflict   <= 1'b0;
      r_cmd_change <= 1'b0;
    end else begin
      r_turn_left  <= w_left_nxt;
      r_turn_right <= w_right_nxt;
      r_emergency  <= w_emerg_nxt;
      r_conflict   <= w_conflict_nxt;
      r_cmd_change <= w_change_nxt;
    end
  end

  assign bus.turn_left  = r_turn_left;
  assign bus.turn_right = r_turn_right;
  assign bus.emergency  = r_emergency;
  assign bus.conflict   = r_conflict;
  assign bus.cmd_change = r_cmd_change;

endmodule

// File: tb/tb_vlc_switch_conditioner.sv
// -----------------------------------------------------------------------------
// tb_vlc_switch_conditioner
// Self-checking bench for vlc_switch_conditioner (SAMPLE_DIV=4, DEB_COUNT=3).
// A reference model kept in the bench stores the switch history since reset
// and applies the debounce/arbitration rules to it; each scenario task
// compares the DUT against it every cycle and adds its own scenario checks.
// Honours VLC_HAZARD_TOGGLE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_vlc_switch_conditioner;
  localparam int SAMPLE_DIV = 4;
  localparam int DEB_COUNT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vlc_switch_conditioner_if bus();

  vlc_switch_conditioner #(.SAMPLE_DIV(SAMPLE_DIV), .DEB_COUNT(DEB_COUNT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [2:0] hist[$];      // switch levels seen at each edge since reset
  int         edges;        // edges since reset release
  logic [2:0] m_stable;
  int         m_run[3];
  logic       m_latch;
  logic [4:0] m_out;        // {emergency, left, right, conflict, cmd_change}

  function automatic logic [4:0] obs();
    return {bus.emergency, bus.turn_left, bus.turn_right, bus.conflict, bus.cmd_change};
  endfunction

  // {emergency, left, right, conflict} from the accepted switch levels
  function automatic logic [3:0] arbitrate(logic [2:0] st, logic latch);
    logic h;
`ifdef VLC_HAZARD_TOGGLE_EN
    h = latch;
`else
    h = st[2];
`endif
    if (h) return 4'b1000;
    if (st[0] && st[1]) return 4'b0001;
    return {1'b0, st[0], st[1], 1'b0};
  endfunction

  task automatic model_reset();
    hist.delete();
    edges    = 0;
    m_stable = 3'b000;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
    m_latch  = 1'b0;
    m_out    = 5'b00000;
  endtask

  // Advance one clock edge (model and DUT) and return at the next falling edge.
  task automatic step();
    logic [3:0] a;
    logic [2:0] synced;
    @(posedge clk);
    a = arbitrate(m_stable, m_latch);
    m_out = {a, (a[3:1] != m_out[4:2])};
    hist.push_back({bus.sw_emerg, bus.sw_right, bus.sw_left});
    synced = (hist.size() >= 3) ? hist[hist.size() - 3] : 3'b000;
    if ((edges % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
      for (int c = 0; c < 3; c++) begin
        if (synced[c] != m_stable[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB_COUNT) begin
            m_stable[c] = ~m_stable[c];
            m_run[c] = 0;
            if (c == 2 && m_stable[2]) m_latch = ~m_latch;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    edges++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    bus.sw_left = 1'b0; bus.sw_right = 1'b0; bus.sw_emerg = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_values: got %b want 00000", obs());
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs(), m_out);
      end
    end
  endtask

  task automatic test_left_hold();
    int lat = -1;
    int pulses = 0;
    apply_reset();
    bus.sw_left = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL left_hold cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (bus.cmd_change) pulses++;
      if (lat < 0 && bus.turn_left) lat = i;
    end
    n_checks++;
    if (lat < 1 || lat > 15) begin
      n_fail++; $display("FAIL left_latency: got %0d want 1..15", lat);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL left_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if ({bus.turn_right, bus.emergency} !== 2'b00) begin
      n_fail++; $display("FAIL left_others: got %b want 00", {bus.turn_right, bus.emergency});
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 42; i++) begin
      bus.sw_left = (i >= 7 && i < 10) ? 1'b1 : 1'b0;
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL glitch cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (bus.turn_left || bus.cmd_change) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reached_output: got %b want 0", seen);
    end
  endtask

  task automatic test_conflict();
    int pulses = 0;
    apply_reset();
    bus.sw_left = 1'b1; bus.sw_right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL conflict cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (bus.cmd_change) pulses++;
    end
    n_checks++;
    if ({bus.conflict, bus.turn_left, bus.turn_right, pulses} !== {3'b100, 32'd0}) begin
      n_fail++; $display("FAIL conflict_state: got c=%b l=%b r=%b pulses=%0d want c=1 l=0 r=0 pulses=0",
                         bus.conflict, bus.turn_left, bus.turn_right, pulses);
    end
    bus.sw_emerg = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL hazard_over_conflict cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (bus.cmd_change) pulses++;
    end
    n_checks++;
    if ({bus.emergency, bus.conflict} !== 2'b10 || pulses != 1) begin
      n_fail++; $display("FAIL hazard_state: got e=%b c=%b pulses=%0d want e=1 c=0 pulses=1",
                         bus.emergency, bus.conflict, pulses);
    end
  endtask

  task automatic test_bounce();
    int falls = 0;
    int pulses = 0;
    logic prev;
    apply_reset();
    bus.sw_right = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (bus.turn_right !== 1'b1) begin
      n_fail++; $display("FAIL bounce_setup: got %b want 1", bus.turn_right);
    end
    prev = bus.turn_right;
    for (int i = 0; i < 50; i++) begin
      if (i < 20) begin
        if (i % 2 == 0) bus.sw_right = ~bus.sw_right;
      end else begin
        bus.sw_right = 1'b0;
      end
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL bounce cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (prev && !bus.turn_right) falls++;
      if (bus.cmd_change) pulses++;
      prev = bus.turn_right;
    end
    n_checks++;
    if (falls != 1 || pulses != 1 || bus.turn_right !== 1'b0) begin
      n_fail++; $display("FAIL bounce_result: got falls=%0d pulses=%0d right=%b want 1 1 0",
                         falls, pulses, bus.turn_right);
    end
  endtask

  task automatic test_reset_mid();
    logic reached = 1'b0;
    apply_reset();
    bus.sw_left = 1'b1;
    for (int i = 0; i < 40 && !reached; i++) begin
      step();
      if (m_run[0] == 2) reached = 1'b1;
    end
    n_checks++;
    if (reached !== 1'b1 || bus.turn_left !== 1'b0) begin
      n_fail++; $display("FAIL midreset_setup: got reached=%b left=%b want 1 0", reached, bus.turn_left);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++; $display("FAIL midreset_immediate: got %b want 00000", obs());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // a full debounce from scratch: 2 sync edges, strobes at edges 3/7/11, output at 12
    for (int i = 1; i <= 13; i++) begin
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL midreset cyc %0d: got %b want %b", i, obs(), m_out);
      end
      if (i == 12) begin
        n_checks++;
        if (bus.turn_left !== 1'b0) begin
          n_fail++; $display("FAIL midreset_early: got %b want 0", bus.turn_left);
        end
      end
    end
    n_checks++;
    if (bus.turn_left !== 1'b1) begin
      n_fail++; $display("FAIL midreset_full: got %b want 1", bus.turn_left);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) bus.sw_left  = ~bus.sw_left;
      if ($urandom_range(0, 11) == 0) bus.sw_right = ~bus.sw_right;
      if ($urandom_range(0, 15) == 0) bus.sw_emerg = ~bus.sw_emerg;
      step();
      n_checks++;
      if (obs() !== m_out) begin
        n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs(), m_out);
      end
    end
  endtask

`ifdef VLC_HAZARD_TOGGLE_EN
  task automatic test_toggle();
    int pulses = 0;
    logic [3:0] phase_e;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      bus.sw_emerg = (p % 2 == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        n_checks++;
        if (obs() !== m_out) begin
          n_fail++; $display("FAIL toggle phase %0d cyc %0d: got %b want %b", p, i, obs(), m_out);
        end
        if (bus.cmd_change) pulses++;
      end
      phase_e[p] = bus.emergency;
    end
    n_checks++;
    if (phase_e !== 4'b0011 || pulses != 2) begin
      n_fail++; $display("FAIL toggle_result: got phases=%b pulses=%0d want 0011 2", phase_e, pulses);
    end
  endtask
`endif

  initial begin
    bus.sw_left = 1'b0; bus.sw_right = 1'b0; bus.sw_emerg = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_left_hold();
    test_glitch();
    test_conflict();
    test_bounce();
    test_reset_mid();
`ifdef VLC_HAZARD_TOGGLE_EN
    test_toggle();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
